// File: rtl/uart_protocol.sv
// 8N1 UART transmitter and receiver with the serial line looped back internally.
// Define UART_PARITY_EN to insert an even parity bit after bit 7 in both directions.
module uart_protocol #(
    parameter int CLKS_PER_BIT = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_out
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_ERR} rx_state_t;
`else
    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_ERR} rx_state_t;
`endif

    tx_state_t tx_state, tx_next;
    rx_state_t rx_state, rx_next;
    logic          send_q, request;
    logic [CW-1:0] tx_cnt, tx_cnt_next, rx_cnt, rx_cnt_next;
    logic [2:0]    tx_idx, tx_idx_next, rx_idx, rx_idx_next;
    logic [7:0]    tx_data, tx_data_next, rx_shift, rx_shift_next, data_out_next;
    logic          line, line_next, done_next, tx_bit_end, rx_frame_ok;

    assign request    = send & ~send_q;
    assign tx_bit_end = (tx_cnt == BIT_LAST);

`ifdef UART_PARITY_EN
    logic par_ok, par_ok_next;
    assign rx_frame_ok = par_ok;
`else
    assign rx_frame_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            send_q   <= 1'b0;
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_data  <= '0;
            line     <= 1'b1;
            busy     <= 1'b0;
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            done     <= 1'b0;
            data_out <= '0;
        end else begin
            send_q   <= send;
            tx_state <= tx_next;
            tx_cnt   <= tx_cnt_next;
            tx_idx   <= tx_idx_next;
            tx_data  <= tx_data_next;
            line     <= line_next;
            busy     <= (tx_next != T_IDLE);
            rx_state <= rx_next;
            rx_cnt   <= rx_cnt_next;
            rx_idx   <= rx_idx_next;
            rx_shift <= rx_shift_next;
            done     <= done_next;
            data_out <= data_out_next;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) par_ok <= 1'b0;
        else        par_ok <= par_ok_next;
    end
`endif

    // Transmitter: line and busy are registered from the next state so they align with it.
    always_comb begin
        tx_next      = tx_state;
        tx_idx_next  = tx_idx;
        tx_data_next = tx_data;
        tx_cnt_next  = tx_bit_end ? '0 : tx_cnt + 1'b1;
        case (tx_state)
            T_IDLE: begin
                tx_cnt_next = '0;
                tx_idx_next = '0;
                if (request) begin
                    tx_data_next = data_in;
                    tx_next      = T_START;
                end
            end
            T_START: if (tx_bit_end) tx_next = T_DATA;
            T_DATA: if (tx_bit_end) begin
                tx_idx_next = tx_idx + 1'b1;
`ifdef UART_PARITY_EN
                if (tx_idx == 3'd7) tx_next = T_PARITY;
`else
                if (tx_idx == 3'd7) tx_next = T_STOP;
`endif
            end
`ifdef UART_PARITY_EN
            T_PARITY: if (tx_bit_end) tx_next = T_STOP;
`endif
            T_STOP: if (tx_bit_end) tx_next = T_IDLE;
            default: tx_next = T_IDLE;
        endcase
        case (tx_next)
            T_START:  line_next = 1'b0;
            T_DATA:   line_next = tx_data_next[tx_idx_next];
`ifdef UART_PARITY_EN
            T_PARITY: line_next = ^tx_data_next;
`endif
            default:  line_next = 1'b1;
        endcase
    end

    // Receiver: start bit re-checked at its centre, later bits sampled a full bit apart.
    always_comb begin
        rx_next       = rx_state;
        rx_cnt_next   = rx_cnt + 1'b1;
        rx_idx_next   = rx_idx;
        rx_shift_next = rx_shift;
        done_next     = 1'b0;
        data_out_next = data_out;
`ifdef UART_PARITY_EN
        par_ok_next   = par_ok;
`endif
        case (rx_state)
            R_IDLE: begin
                rx_cnt_next = '0;
                if (!line) rx_next = R_START;
            end
            R_START: if (rx_cnt == HALF_LAST) begin
                rx_cnt_next = '0;
                rx_idx_next = '0;
                rx_next     = line ? R_IDLE : R_DATA;
            end
            R_DATA: if (rx_cnt == BIT_LAST) begin
                rx_cnt_next   = '0;
                rx_shift_next = {line, rx_shift[7:1]};
                rx_idx_next   = rx_idx + 1'b1;
`ifdef UART_PARITY_EN
                if (rx_idx == 3'd7) rx_next = R_PARITY;
`else
                if (rx_idx == 3'd7) rx_next = R_STOP;
`endif
            end
`ifdef UART_PARITY_EN
            R_PARITY: if (rx_cnt == BIT_LAST) begin
                rx_cnt_next = '0;
                par_ok_next = (line == ^rx_shift);
                rx_next     = R_STOP;
            end
`endif
            R_STOP: if (rx_cnt == BIT_LAST) begin
                rx_cnt_next = '0;
                if (line && rx_frame_ok) begin
                    data_out_next = rx_shift;
                    done_next     = 1'b1;
                end
                rx_next = line ? R_IDLE : R_ERR;
            end
            R_ERR: begin
                rx_cnt_next = '0;
                if (line) rx_next = R_IDLE;
            end
            default: rx_next = R_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_protocol.sv
// Directed bench for uart_protocol: framing length, latency, received bytes and
// the discard rules for idle data, busy edges and reset.
module tb_uart_protocol;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       send = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       busy, done;
    logic [7:0] data_out;

    int total = 0, passed = 0, fails = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, busy_cnt = 0, req_cyc = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    uart_protocol #(.CLKS_PER_BIT(40)) dut (
        .clk(clk), .reset(reset), .send(send), .data_in(data_in),
        .busy(busy), .done(done), .data_out(data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            rx_q.push_back(data_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_send(input logic [7:0] b);
        @(negedge clk);
        data_in = b;
        send    = 1'b1;
        req_cyc = cyc;
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int b0, d0, lat;

    initial begin
        // reset state
        idle_cycles(3);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_data_out", {24'd0, data_out}, 32'h00);
        reset = 1'b1;
        idle_cycles(5);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // single frame 0x18
        b0 = busy_cnt; d0 = done_cnt;
        pulse_send(8'h18);
        wait_idle("f18_idle");
        idle_cycles(20);
        check("f18_busy_len", busy_cnt - b0, 32'd400);
        check("f18_done_cnt", done_cnt - d0, 32'd1);
        check("f18_data_out", {24'd0, data_out}, 32'h18);
        lat = done_cyc - req_cyc - 1;
        check("f18_latency", {31'd0, (lat >= 380 && lat <= 382)}, 32'd1);

        // data_in change without send edge
        b0 = busy_cnt; d0 = done_cnt;
        @(negedge clk); data_in = 8'h45;
        idle_cycles(500);
        check("nosend_busy", busy_cnt - b0, 32'd0);
        check("nosend_done", done_cnt - d0, 32'd0);
        check("nosend_data_out", {24'd0, data_out}, 32'h18);
        d0 = done_cnt;
        pulse_send(8'h00);
        wait_idle("f00_idle");
        idle_cycles(20);
        check("f00_done_cnt", done_cnt - d0, 32'd1);
        check("f00_data_out", {24'd0, data_out}, 32'h00);

        // send edge while reset held
        b0 = busy_cnt; d0 = done_cnt;
        @(negedge clk); reset = 1'b0;
        pulse_send(8'h21);
        idle_cycles(5);
        check("rstsend_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        idle_cycles(500);
        check("rstsend_busy_cnt", busy_cnt - b0, 32'd0);
        check("rstsend_done", done_cnt - d0, 32'd0);
        pulse_send(8'h07);
        wait_idle("f07_idle");
        idle_cycles(20);
        check("f07_data_out", {24'd0, data_out}, 32'h07);

        // back-to-back frames
        rx_q.delete();
        exp_q = '{8'h55, 8'hAA, 8'hFF, 8'h0F, 8'hF0, 8'h01, 8'h80};
        d0 = done_cnt;
        foreach (exp_q[i]) begin
            pulse_send(exp_q[i]);
            wait_idle("b2b_idle");
        end
        idle_cycles(20);
        check("b2b_done_cnt", done_cnt - d0, 32'd7);
        check("b2b_rx_size", rx_q.size(), 32'd7);
        foreach (exp_q[i])
            check($sformatf("b2b_byte%0d", i), (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hFFFF, {24'd0, exp_q[i]});

        // edges while busy are dropped; a held send level does not retransmit
        rx_q.delete();
        b0 = busy_cnt; d0 = done_cnt;
        @(negedge clk); data_in = 8'h51; send = 1'b1;
        idle_cycles(100);
        send = 1'b0;
        idle_cycles(2);
        data_in = 8'h96; send = 1'b1;
        idle_cycles(50);
        send = 1'b0;
        idle_cycles(2);
        data_in = 8'h48; send = 1'b1;
        wait_idle("busyedge_idle");
        idle_cycles(500);
        send = 1'b0;
        check("busyedge_busy_len", busy_cnt - b0, 32'd400);
        check("busyedge_done_cnt", done_cnt - d0, 32'd1);
        check("busyedge_rx0", (rx_q.size() > 0) ? {24'd0, rx_q[0]} : 32'hFFFF, 32'h51);
        check("busyedge_data_out", {24'd0, data_out}, 32'h51);

        // reset mid-frame aborts
        d0 = done_cnt;
        pulse_send(8'h88);
        idle_cycles(150);
        check("midrst_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_data_out", {24'd0, data_out}, 32'h00);
        idle_cycles(10);
        reset = 1'b1;
        idle_cycles(500);
        check("midrst_done", done_cnt - d0, 32'd0);
        check("midrst_data_out_after", {24'd0, data_out}, 32'h00);
        check("midrst_busy_after", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
